// File: rtl/atm_pin_entry.sv
// Keypad PIN collector: buffers BCD digits, compares against the stored PIN and
// reports each attempt. Optional inactivity abort enabled by `define ATM_PIN_TIMEOUT_EN.
module atm_pin_entry #(
    parameter int PIN_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    card_inserted,
    input  logic                    key_valid,
    input  logic [3:0]              key_code,
    output logic                    key_ready,
    input  logic [4*PIN_DIGITS-1:0] stored_pin,
    output logic                    pin_entered,
    output logic                    pin_correct,
    output logic [2:0]              digit_count,
    output logic                    timeout
);

    localparam int         PIN_W     = 4 * PIN_DIGITS;
    localparam logic [2:0] FULL      = 3'(PIN_DIGITS);
    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    if (PIN_DIGITS < 1 || PIN_DIGITS > 7 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("atm_pin_entry: PIN_DIGITS must be 1..7 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMPARE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [PIN_W-1:0] buffer, buffer_n;
    logic [PIN_W+3:0] shifted;
    logic [2:0]       count, count_n;
    logic             short_q, short_n;
    logic             pin_correct_n;
    logic             card_q;

`ifdef ATM_PIN_TIMEOUT_EN
    localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] timer, timer_n;
`endif

    // New digit enters at the LS nibble; the oldest digit falls out of the top.
    assign shifted     = {buffer, key_code};
    assign digit_count = count;

    always_comb begin
        state_n       = state;
        buffer_n      = buffer;
        count_n       = count;
        short_n       = short_q;
        pin_correct_n = pin_correct;
        key_ready     = 1'b0;
        pin_entered   = 1'b0;
        timeout       = 1'b0;
`ifdef ATM_PIN_TIMEOUT_EN
        timer_n       = timer;
`endif
        case (state)
            IDLE: begin
                if (card_inserted && !card_q) begin
                    state_n  = COLLECT;
                    buffer_n = '0;
                    count_n  = 3'd0;
`ifdef ATM_PIN_TIMEOUT_EN
                    timer_n  = '0;
`endif
                end
            end

            COLLECT: begin
                key_ready = 1'b1;
                // Card removal beats any key offered in the same cycle.
                if (!card_inserted) begin
                    state_n  = IDLE;
                    buffer_n = '0;
                    count_n  = 3'd0;
                end else if (key_valid) begin
`ifdef ATM_PIN_TIMEOUT_EN
                    timer_n = '0;
`endif
                    if (key_code <= 4'd9) begin
                        if (count < FULL) begin
                            buffer_n = shifted[PIN_W-1:0];
                            count_n  = count + 3'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        buffer_n = '0;
                        count_n  = 3'd0;
                    end else if (key_code == KEY_ENTER) begin
                        state_n = COMPARE;
                        short_n = (count != FULL);
                    end
                end else begin
`ifdef ATM_PIN_TIMEOUT_EN
                    if (timer == TMR_LAST) begin
                        timeout  = 1'b1;
                        state_n  = IDLE;
                        buffer_n = '0;
                        count_n  = 3'd0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
`endif
                end
            end

            COMPARE: begin
                if (!card_inserted) begin
                    state_n  = IDLE;
                    buffer_n = '0;
                    count_n  = 3'd0;
                end else begin
                    state_n       = REPORT;
                    pin_correct_n = !short_q && (buffer == stored_pin);
                end
            end

            REPORT: begin
                pin_entered = 1'b1;
                buffer_n    = '0;
                count_n     = 3'd0;
`ifdef ATM_PIN_TIMEOUT_EN
                timer_n     = '0;
`endif
                state_n     = card_inserted ? COLLECT : IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            buffer      <= '0;
            count       <= 3'd0;
            short_q     <= 1'b0;
            pin_correct <= 1'b0;
            card_q      <= 1'b0;
`ifdef ATM_PIN_TIMEOUT_EN
            timer       <= '0;
`endif
        end else begin
            state       <= state_n;
            buffer      <= buffer_n;
            count       <= count_n;
            short_q     <= short_n;
            pin_correct <= pin_correct_n;
            card_q      <= card_inserted;
`ifdef ATM_PIN_TIMEOUT_EN
            timer       <= timer_n;
`endif
        end
    end

endmodule

// File: tb/tb_atm_pin_entry.sv
// Directed bench for atm_pin_entry: per-cycle vector table plus hand-written
// sequences for mid-entry reset and the optional inactivity timeout.
module tb_atm_pin_entry;

    localparam logic [3:0] K_CLR = 4'hA;
    localparam logic [3:0] K_ENT = 4'hB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        card_inserted = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [15:0] stored_pin = 16'h1234;
    logic        key_ready;
    logic        pin_entered;
    logic        pin_correct;
    logic [2:0]  digit_count;
    logic        timeout;

    int n_cmp = 0;
    int n_bad = 0;

    atm_pin_entry #(
        .PIN_DIGITS     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .card_inserted (card_inserted),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_ready     (key_ready),
        .stored_pin    (stored_pin),
        .pin_entered   (pin_entered),
        .pin_correct   (pin_correct),
        .digit_count   (digit_count),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       card;
        logic       kv;
        logic [3:0] kc;
        logic       kr;
        logic       pe;
        logic       pc;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c, input logic kv, input logic [3:0] kc,
                       input logic kr, input logic pe, input logic pc, input logic [2:0] cnt);
        vec_t v;
        v.card = c; v.kv = kv; v.kc = kc; v.kr = kr; v.pe = pe; v.pc = pc; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic kv, input logic [3:0] kc);
        card_inserted = c;
        key_valid     = kv;
        key_code      = kc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic kr, input logic pe, input logic pc,
                           input logic [2:0] cnt, input logic to);
        chk({tag, ".key_ready"},   32'(key_ready),   32'(kr));
        chk({tag, ".pin_entered"}, 32'(pin_entered), 32'(pe));
        chk({tag, ".pin_correct"}, 32'(pin_correct), 32'(pc));
        chk({tag, ".digit_count"}, 32'(digit_count), 32'(cnt));
        chk({tag, ".timeout"},     32'(timeout),     32'(to));
    endtask

    initial begin
        int digits[4];
        digits = '{1, 2, 3, 4};

        // Reset held with a card and a key present must still win.
        reset = 1'b0;
        drive(1'b1, 1'b1, 4'd1);
        repeat (3) tick();
        chk_all("reset", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        drive(1'b0, 1'b0, 4'd0);
        reset = 1'b1;
        tick();
        chk_all("idle_no_card", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // T1: correct PIN
        add(1,0,0,     0,0,0,0);
        add(1,1,1,     1,0,0,0);
        add(1,1,2,     1,0,0,1);
        add(1,1,3,     1,0,0,2);
        add(1,1,4,     1,0,0,3);
        add(1,1,K_ENT, 1,0,0,4);
        add(1,0,0,     0,0,0,4);
        add(1,0,0,     0,1,1,4);
        add(1,0,0,     1,0,1,0);
        // T2: wrong PIN, then correct without a new card edge
        add(1,1,1,     1,0,1,0);
        add(1,1,2,     1,0,1,1);
        add(1,1,3,     1,0,1,2);
        add(1,1,5,     1,0,1,3);
        add(1,1,K_ENT, 1,0,1,4);
        add(1,0,0,     0,0,1,4);
        add(1,0,0,     0,1,0,4);
        add(1,0,0,     1,0,0,0);
        add(1,1,1,     1,0,0,0);
        add(1,1,2,     1,0,0,1);
        add(1,1,3,     1,0,0,2);
        add(1,1,4,     1,0,0,3);
        add(1,1,K_ENT, 1,0,0,4);
        add(1,0,0,     0,0,0,4);
        add(1,0,0,     0,1,1,4);
        add(1,0,0,     1,0,1,0);
        // T3: short entry
        add(1,1,1,     1,0,1,0);
        add(1,1,2,     1,0,1,1);
        add(1,1,K_ENT, 1,0,1,2);
        add(1,0,0,     0,0,1,2);
        add(1,0,0,     0,1,0,2);
        add(1,0,0,     1,0,0,0);
        // T3: overflow digit dropped
        add(1,1,1,     1,0,0,0);
        add(1,1,2,     1,0,0,1);
        add(1,1,3,     1,0,0,2);
        add(1,1,4,     1,0,0,3);
        add(1,1,9,     1,0,0,4);
        add(1,1,K_ENT, 1,0,0,4);
        add(1,0,0,     0,0,0,4);
        add(1,0,0,     0,1,1,4);
        add(1,0,0,     1,0,1,0);
        // Ignored codes, then ENTER on an empty buffer
        add(1,1,4'hC,  1,0,1,0);
        add(1,1,4'hF,  1,0,1,0);
        add(1,1,K_ENT, 1,0,1,0);
        add(1,0,0,     0,0,1,0);
        add(1,0,0,     0,1,0,0);
        add(1,0,0,     1,0,0,0);
        // T4: held keys, each held cycle is a press
        add(1,1,9,     1,0,0,0);
        add(1,1,9,     1,0,0,1);
        add(1,1,9,     1,0,0,2);
        add(1,1,9,     1,0,0,3);
        add(1,1,9,     1,0,0,4);
        add(1,1,K_CLR, 1,0,0,4);
        add(1,1,K_CLR, 1,0,0,0);
        add(1,1,1,     1,0,0,0);
        add(1,1,2,     1,0,0,1);
        add(1,1,3,     1,0,0,2);
        add(1,1,4,     1,0,0,3);
        add(1,1,K_ENT, 1,0,0,4);
        add(1,1,K_ENT, 0,0,0,4);
        add(1,1,K_ENT, 0,1,1,4);
        add(1,0,0,     1,0,1,0);
        add(1,0,0,     1,0,1,0);
        // T5: card removed in COLLECT, key in same cycle loses
        add(1,1,1,     1,0,1,0);
        add(1,1,2,     1,0,1,1);
        add(0,1,3,     1,0,1,2);
        add(0,1,4,     0,0,1,0);
        add(0,0,0,     0,0,1,0);
        // Card removed in COMPARE: no report
        add(1,0,0,     0,0,1,0);
        add(1,1,1,     1,0,1,0);
        add(1,1,2,     1,0,1,1);
        add(1,1,3,     1,0,1,2);
        add(1,1,5,     1,0,1,3);
        add(1,1,K_ENT, 1,0,1,4);
        add(0,0,0,     0,0,1,4);
        add(0,0,0,     0,0,1,0);
        add(0,0,0,     0,0,1,0);
        // Card removed in REPORT returns to IDLE; re-entry needs a new edge
        add(1,0,0,     0,0,1,0);
        add(1,1,K_ENT, 1,0,1,0);
        add(1,0,0,     0,0,1,0);
        add(0,0,0,     0,1,0,0);
        add(0,0,0,     0,0,0,0);
        add(1,1,1,     0,0,0,0);
        add(1,0,0,     1,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].card, vecs[i].kv, vecs[i].kc);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].kr, vecs[i].pe, vecs[i].pc, vecs[i].cnt, 1'b0);
            @(posedge clk);
            #1;
        end

        // T5: reset in the middle of an entry, after a correct attempt set pin_correct
        foreach (digits[i]) begin
            drive(1'b1, 1'b1, 4'(digits[i]));
            tick();
        end
        drive(1'b1, 1'b1, K_ENT);
        tick();
        drive(1'b1, 1'b0, 4'd0);
        tick();
        chk("pre_reset.pin_entered", 32'(pin_entered), 32'd1);
        chk("pre_reset.pin_correct", 32'(pin_correct), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 4'(digits[i]));
            tick();
        end
        drive(1'b1, 1'b0, 4'd0);
        #1;
        chk("pre_reset.digit_count", 32'(digit_count), 32'd3);
        reset = 1'b0;
        tick();
        chk_all("mid_reset", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        reset = 1'b1;
        tick();
        chk_all("post_reset", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);

`ifdef ATM_PIN_TIMEOUT_EN
        // T6: one key then idle; abort 15 edges after the key is taken
        drive(1'b1, 1'b1, 4'd5);
        tick();
        drive(1'b1, 1'b0, 4'd0);
        #1;
        chk("to.after_key", 32'(timeout), 32'd0);
        for (int j = 1; j < 15; j++) begin
            tick();
            chk($sformatf("to.wait%0d", j), 32'(timeout), 32'd0);
        end
        tick();
        chk_all("to.pulse", 1'b1, 1'b0, 1'b0, 3'd1, 1'b1);
        tick();
        chk_all("to.idle", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        drive(1'b1, 1'b1, 4'd1);
        tick();
        chk_all("to.key_ignored", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        drive(1'b0, 1'b0, 4'd0);
        tick();
        drive(1'b1, 1'b0, 4'd0);
        tick();
        chk_all("to.rearm", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        // A key offered in the terminal cycle keeps the session alive
        drive(1'b1, 1'b1, 4'd7);
        tick();
        drive(1'b1, 1'b0, 4'd0);
        repeat (15) tick();
        drive(1'b1, 1'b1, 4'd8);
        #1;
        chk("to.key_wins.timeout", 32'(timeout), 32'd0);
        tick();
        drive(1'b1, 1'b0, 4'd0);
        #1;
        chk_all("to.key_wins", 1'b1, 1'b0, 1'b0, 3'd2, 1'b0);
`else
        drive(1'b1, 1'b0, 4'd0);
        repeat (40) tick();
        chk_all("no_timeout", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
